// File: rtl/logic_accumulator_pkg.sv
// Shared widths, opcodes and FSM encoding for the 4-bit logic datapath.
// Imported by the accumulator stage and the reusable op unit.
package logic_accumulator_pkg;

    localparam int k  = 4;
    localparam int CW = 8;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_NOT   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } accState_t;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise op between a and b selected by op; zero latency.
// No state and no flow control; the caller decides when result is used.
module logic_op_unit
    import logic_accumulator_pkg::*;
#(
    parameter int W = k
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result
);

    always_comb begin
        result = a;
        case (op)
            OP_NOP:   result = a;
            OP_LOAD:  result = b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOR:   result = ~(a | b);
            OP_NOT:   result = ~a;
            OP_CLEAR: result = '0;
            default:  result = a;
        endcase
    end

endmodule

// File: rtl/logic_accumulator.sv
// Accumulator stage: capture command, apply op to acc, present result; 2-cycle latency, 1 cmd / 3 cycles.
// Holds result and flags in DONE until res_ready; cmd_ready is low outside IDLE.
module logic_accumulator
    import logic_accumulator_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [k-1:0]  cmd_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [k-1:0]  res_data,
    output logic          res_zero,
    output logic          res_ones,
    output logic [CW-1:0] op_count
);

    accState_t     state;
    accState_t     nextState;
    logic [2:0]    latchOp;
    logic [k-1:0]  latchB;
    logic [k-1:0]  acc;
    logic [k-1:0]  opResult;
    logic          zeroFlag;
    logic          onesFlag;
    logic [CW-1:0] opCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (cmd_valid) nextState = S_EXEC;
            S_EXEC:  nextState = S_DONE;
            S_DONE:  if (res_ready) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE:  cmd_ready = 1'b1;
            S_DONE:  res_valid = 1'b1;
            default: begin
                cmd_ready = 1'b0;
                res_valid = 1'b0;
            end
        endcase
    end

    logic_op_unit #(.W(k)) opUnit (
        .op     (latchOp),
        .a      (acc),
        .b      (latchB),
        .result (opResult)
    );

    // Flags are registered alongside acc so they always agree with res_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latchOp  <= OP_NOP;
            latchB   <= '0;
            acc      <= '0;
            zeroFlag <= 1'b1;
            onesFlag <= 1'b0;
            opCount  <= '0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                latchOp <= cmd_op;
                latchB  <= cmd_data;
            end
            if (state == S_EXEC) begin
                acc      <= opResult;
                zeroFlag <= (opResult == '0);
                onesFlag <= &opResult;
                if (opCount != {CW{1'b1}}) begin
                    opCount <= opCount + 1'b1;
                end
            end
        end
    end

    assign res_data = acc;
    assign res_zero = zeroFlag;
    assign res_ones = onesFlag;
    assign op_count = opCount;

endmodule

// File: tb/tb_logic_accumulator.sv
// Directed plus randomized bench for logic_accumulator against a simple arithmetic reference model.
module tb_logic_accumulator;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_zero;
    logic       res_ones;
    logic [7:0] op_count;

    int errors = 0;
    int checks = 0;

    int refAcc = 0;
    int refCnt = 0;

    logic_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_ones  (res_ones),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference result from the opcode table using integer arithmetic on 0..15.
    function automatic int refOp(input int op, input int a, input int b);
        int r;
        if (op == 1)      r = b;
        else if (op == 2) r = a & b;
        else if (op == 3) r = a | b;
        else if (op == 4) r = a ^ b;
        else if (op == 5) r = 15 - (a | b);
        else if (op == 6) r = 15 - a;
        else if (op == 7) r = 0;
        else              r = a;
        return r;
    endfunction

    task automatic checkReset(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"},  res_data,  0);
        check({tag, "_res_zero"},  res_zero,  1);
        check({tag, "_res_ones"},  res_ones,  0);
        check({tag, "_op_count"},  op_count,  0);
    endtask

    // One full transaction; stall>0 holds res_ready low (with cmd_valid high) in DONE.
    task automatic doCmd(input int op, input int b, input int stall, input bit full);
        int waitCnt;
        int heldData;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op[2:0];
        cmd_data  = b[3:0];
        res_ready = (stall == 0);
        if (full) check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        if (stall == 0) cmd_valid = 1'b0;
        cmd_op   = 3'(7 - op);
        cmd_data = 4'(15 - b);
        refAcc = refOp(op, refAcc, b);
        if (refCnt < 255) refCnt++;
        if (full) check("cmd_ready_exec", cmd_ready, 0);
        waitCnt = 0;
        while (!res_valid && waitCnt < 10) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        check("res_valid_rise", res_valid, 1);
        if (full) check("latency_edges", waitCnt, 1);
        check("res_data", res_data, refAcc);
        if (full) begin
            check("res_zero", res_zero, (refAcc == 0));
            check("res_ones", res_ones, (refAcc == 15));
        end
        check("op_count", op_count, refCnt);
        heldData = res_data;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_cmd_ready", cmd_ready, 0);
            check("stall_res_valid", res_valid, 1);
            check("stall_res_data", res_data, heldData);
            check("stall_res_zero", res_zero, (refAcc == 0));
            check("stall_op_count", op_count, refCnt);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        if (full) begin
            check("retire_res_valid", res_valid, 0);
            check("retire_cmd_ready", cmd_ready, 1);
        end
        res_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        res_ready = 1'b0;
        #12;
        checkReset("reset");
        @(negedge clk);
        rst = 1'b0;

        doCmd(1, 4'b1010, 0, 1'b1);
        doCmd(1, 4'b1111, 0, 1'b1);
        doCmd(5, 4'b1010, 0, 1'b1);
        check("nor_zero_data", res_data, 0);
        doCmd(6, 4'b0000, 0, 1'b1);
        check("not_ones_flag", res_ones, 1);
        check("count_after_nor_not", op_count, 4);

        doCmd(1, 4'b1100, 0, 1'b1);
        doCmd(4, 4'b1010, 0, 1'b1);
        doCmd(2, 4'b0011, 0, 1'b1);
        doCmd(3, 4'b1000, 0, 1'b1);
        doCmd(7, 4'b1111, 0, 1'b1);

        doCmd(1, 4'b0110, 5, 1'b1);
        doCmd(3, 4'b0001, 0, 1'b1);

        // Random commands with random downstream stalls.
        for (int n = 0; n < 40; n++) begin
            doCmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), 1'b1);
        end

        // Asynchronous reset while the LOAD sits in EXEC.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 4'b0101;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        refAcc = 0;
        refCnt = 0;
        checkReset("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_no_res_valid", res_valid, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_res_valid", res_valid, 0);
        check("post_rst_op_count", op_count, 0);

        doCmd(1, 4'b1001, 0, 1'b1);
        for (int n = 0; n < 260; n++) begin
            doCmd(0, int'($urandom_range(0, 15)), 0, 1'b0);
        end
        check("sat_op_count", op_count, 255);
        check("sat_acc_unchanged", res_data, 4'b1001);
        doCmd(0, 4'b0000, 0, 1'b1);
        check("sat_hold", op_count, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
